// File: rtl/jk_pkg.sv
// -----------------------------------------------------------------------------
// jk_pkg
//   Shared JK command encoding and the next-state rule used by every JK cell.
//   The command is just {j,k} viewed as an enum so the cell logic reads as
//   hold/reset/set/toggle rather than raw bit pairs.
// -----------------------------------------------------------------------------
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_cmd_e;

  // Next state of one JK bit. An unknown command (X/Z on j or k) falls to the
  // default arm and yields X; no X-suppression is wanted here.
  function automatic logic jk_next(input jk_cmd_e cmd, input logic q);
    logic nxt;
    case (cmd)
      JK_HOLD: nxt = q;
      JK_RST:  nxt = 1'b0;
      JK_SET:  nxt = 1'b1;
      JK_TGL:  nxt = ~q;
      default: nxt = 1'bx;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// -----------------------------------------------------------------------------
// jk_cell
//   One negative-edge JK stage with synchronous active-low clear.
//   Ports:
//     j, k   in  1  JK command inputs
//     clr    in  1  synchronous clear, active low, sampled on falling clk
//     clk    in  1  clock (falling edge active)
//     q      out 1  registered state
//     q_bar  out 1  combinational ~q
// -----------------------------------------------------------------------------
module jk_cell
  import jk_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic j,
  input  logic k,
  input  logic clr,
  input  logic clk,
  output logic q,
  output logic q_bar
);

  logic r_q;

  // Clear has priority over any J/K command.
  always_ff @(negedge clk) begin
    if (!clr) r_q <= RST_VAL;
    else      r_q <= jk_next(jk_cmd_e'({j, k}), r_q);
  end

  // q_bar is derived, never stored, so it can never disagree with q.
  assign q     = r_q;
  assign q_bar = ~r_q;

endmodule

// File: rtl/jk_ff.sv
// -----------------------------------------------------------------------------
// jk_ff
//   Bank of WIDTH independent negative-edge JK flip-flops with synchronous
//   active-low clear. Port order (j, k, clr, clk, q, q_bar) is relied on by
//   positional instantiations in existing ripple counters.
//   Ports:
//     j, k   in  WIDTH  per-bit JK command
//     clr    in  1      synchronous clear, active low, sampled on falling clk
//     clk    in  1      clock (falling edge active)
//     q      out WIDTH  registered state
//     q_bar  out WIDTH  ~q
// -----------------------------------------------------------------------------
module jk_ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             clr,
  input  logic             clk,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_cell #(
      .RST_VAL (RST_VAL[g])
    ) u_cell (
      .j     (j[g]),
      .k     (k[g]),
      .clr   (clr),
      .clk   (clk),
      .q     (q[g]),
      .q_bar (q_bar[g])
    );
  end

endmodule

// File: tb/tb_jk_ff.sv
// -----------------------------------------------------------------------------
// tb_jk_ff
//   Four DUT configurations share one clock (period 20, falling edges at
//   10, 30, 50, ...):
//     u_a : WIDTH=1, RST_VAL=0
//     u_b : WIDTH=1, RST_VAL=1 (same inputs as u_a)
//     u_w : WIDTH=4, RST_VAL=0
//     u_r : four WIDTH=1 stages wired as a ripple counter, J=K=1
//   A model process follows the JK rules with the characteristic equation
//   Q+ = J&~Q | ~K&Q (the ripple chain as a plain 4-bit count) and is checked
//   1 ns after every edge. Hand-written literals pin the model.
//   All inputs change 2 ns or more after a falling edge, inside the low phase.
// -----------------------------------------------------------------------------
module tb_jk_ff;

  logic       clk;
  logic       j1, k1, clr1;
  logic       q1, qb1, q1s, qb1s;
  logic [3:0] j4, k4, q4, qb4;
  logic       clr4;
  logic       rclr;
  logic [3:0] rq, rqb, rclk;

  int n_cmp = 0;
  int n_bad = 0;

  jk_ff #(.WIDTH(1), .RST_VAL(1'b0)) u_a (
    .j(j1), .k(k1), .clr(clr1), .clk(clk), .q(q1), .q_bar(qb1));
  jk_ff #(.WIDTH(1), .RST_VAL(1'b1)) u_b (
    .j(j1), .k(k1), .clr(clr1), .clk(clk), .q(q1s), .q_bar(qb1s));
  jk_ff #(.WIDTH(4), .RST_VAL(4'b0000)) u_w (
    .j(j4), .k(k4), .clr(clr4), .clk(clk), .q(q4), .q_bar(qb4));

  // Stage 0 runs from clk; stage n runs from q of stage n-1.
  for (genvar g = 0; g < 4; g++) begin : g_rip
    if (g == 0) begin : g_c0
      assign rclk[g] = clk;
    end else begin : g_cn
      assign rclk[g] = rq[g-1];
    end
    jk_ff #(.WIDTH(1), .RST_VAL(1'b0)) u_r (
      .j(1'b1), .k(1'b1), .clr(rclr), .clk(rclk[g]), .q(rq[g]), .q_bar(rqb[g]));
  end

  initial clk = 1'b1;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Clear applied to the ripple chain: a stage only sees the clear when its
  // own clock falls. Stage 0 always clears; stage i+1 is clocked only if
  // stage i falls from 1 to 0.
  function automatic logic [3:0] ripple_clear(input logic [3:0] c);
    logic [3:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      r[i] = 1'b0;
      if (c[i] != 1'b1) break;
    end
    return r;
  endfunction

  // ---------------- reference model ----------------
  logic       m_a, m_b;
  logic [3:0] m_w, m_r;
  bit         v_a = 0, v_w = 0, v_r = 0;

  always @(negedge clk) begin
    if (!clr1) begin
      m_a = 1'b0; m_b = 1'b1; v_a = 1;
    end else begin
      m_a = (j1 & ~m_a) | (~k1 & m_a);
      m_b = (j1 & ~m_b) | (~k1 & m_b);
    end
    if (!clr4) begin
      m_w = 4'b0000; v_w = 1;
    end else begin
      m_w = (j4 & ~m_w) | (~k4 & m_w);
    end
    if (!rclr) begin
      m_r = v_r ? ripple_clear(m_r) : 4'b0000;
      v_r = 1;
    end else begin
      m_r = m_r + 4'd1;
    end
    #1;
    if (v_a) begin
      chk("a_q", {3'b0, q1}, {3'b0, m_a});
      chk("a_qbar", {3'b0, qb1}, {3'b0, ~m_a});
      chk("b_q", {3'b0, q1s}, {3'b0, m_b});
      chk("b_qbar", {3'b0, qb1s}, {3'b0, ~m_b});
    end
    if (v_w) begin
      chk("w_q", q4, m_w);
      chk("w_qbar", qb4, ~m_w);
    end
    if (v_r) begin
      chk("r_q", rq, m_r);
      chk("r_qbar", rqb, ~m_r);
    end
  end

  // Rising edges must leave every state untouched.
  always @(posedge clk) begin
    #1;
    if (v_a) begin
      chk("a_rise", {3'b0, q1}, {3'b0, m_a});
      chk("b_rise", {3'b0, q1s}, {3'b0, m_b});
    end
    if (v_w) chk("w_rise", q4, m_w);
    if (v_r) chk("r_rise", rq, m_r);
  end

  task automatic edge2();
    @(negedge clk);
    #2;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [3:0] iv;
    logic       sj, sk;
    j1 = 1'b1; k1 = 1'b1; clr1 = 1'b0;
    j4 = 4'b0; k4 = 4'b0; clr4 = 1'b0;
    rclr = 1'b0;
    edge2();
    chk("clr_q", {3'b0, q1}, 4'd0);
    chk("clr_qbar", {3'b0, qb1}, 4'd1);
    chk("clr1_q", {3'b0, q1s}, 4'd1);
    chk("rclr_init", rq, 4'd0);

    // Toggle sequence and ripple count run together.
    clr1 = 1'b1; clr4 = 1'b1; rclr = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      edge2();
      iv = i[3:0];
      if (i <= 4) chk("tgl_q", {3'b0, q1}, {3'b0, iv[0]});
      chk("ripple_cnt", rq, iv);
    end
    for (int i = 1; i <= 10; i++) edge2();
    chk("ripple_1010", rq, 4'b1010);
    // At 1010 stage 0 is already 0, so it never falls and the upper stages
    // are not clocked: the clear only reaches bit 0.
    rclr = 1'b0;
    edge2();
    chk("ripple_clr_1010", rq, 4'b1010);
    rclr = 1'b1;
    for (int i = 0; i < 5; i++) edge2();
    chk("ripple_1111", rq, 4'b1111);
    // From 1111 every stage falls in turn, so the clear ripples through.
    rclr = 1'b0;
    edge2();
    chk("ripple_clr_1111", rq, 4'b0000);

    // Truth table from q=0.
    clr1 = 1'b0; edge2();
    clr1 = 1'b1;
    j1 = 1'b1; k1 = 1'b0; edge2(); chk("tt_set", {3'b0, q1}, 4'd1);
    j1 = 1'b0; k1 = 1'b0; edge2(); chk("tt_hold1", {3'b0, q1}, 4'd1);
    j1 = 1'b0; k1 = 1'b1; edge2(); chk("tt_rst", {3'b0, q1}, 4'd0);
    chk("tt_rst_qbar", {3'b0, qb1}, 4'd1);
    j1 = 1'b0; k1 = 1'b0; edge2(); chk("tt_hold0", {3'b0, q1}, 4'd0);

    // Clear beats set.
    clr1 = 1'b0; j1 = 1'b1; k1 = 1'b0; edge2();
    chk("prio_q0", {3'b0, q1}, 4'd0);
    chk("prio_q1", {3'b0, q1s}, 4'd1);
    chk("prio_qbar1", {3'b0, qb1s}, 4'd0);

    // Glitches between falling edges do nothing.
    clr1 = 1'b1; j1 = 1'b0; k1 = 1'b0; edge2();
    #3; clr1 = 1'b0; j1 = 1'b1; k1 = 1'b0;
    #2; clr1 = 1'b1; j1 = 1'b0; k1 = 1'b0;
    #1; chk("glitch_q", {3'b0, q1}, 4'd0);
    chk("glitch_q1", {3'b0, q1s}, 4'd1);
    edge2();
    chk("glitch_after", {3'b0, q1}, 4'd0);

    // 4-bit bank: toggle, set, reset, hold from bit 3 down to bit 0.
    clr4 = 1'b0; edge2();
    clr4 = 1'b1; j4 = 4'b0101; k4 = 4'b1010; edge2();
    chk("w_load", q4, 4'b0101);
    j4 = 4'b1100; k4 = 4'b1010; edge2();
    chk("w_mix", q4, 4'b1101);
    chk("w_mix_qbar", qb4, 4'b0010);

    // Random phase.
    for (int i = 0; i < 300; i++) begin
      j1   = 1'($urandom_range(1));
      k1   = 1'($urandom_range(1));
      clr1 = ($urandom_range(7) != 0);
      j4   = 4'($urandom_range(15));
      k4   = 4'($urandom_range(15));
      clr4 = ($urandom_range(7) != 0);
      rclr = ($urandom_range(5) != 0);
      if ($urandom_range(3) == 0) begin
        sj = j1; sk = k1;
        #2; clr1 = 1'b0; j1 = ~sj; k1 = ~sk;
        #2; clr1 = 1'b1; j1 = sj;  k1 = sk;
      end
      edge2();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: run did not finish, expected end before %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
